// File: rtl/crc16_frame_tx_pkg.sv
// crc16_frame_tx_pkg: shared CRC constants and transmitter state encodings
package crc16_frame_tx_pkg;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;
    typedef enum logic [2:0] {IDLE, DATA, CRC_LO, CRC_HI, WAIT_LAST, GAP} state_t;
endpackage

// File: rtl/crc16_byte_next.sv
// crc16_byte_next: byte-wise reflected CRC-16 (0x8408) update shared by tx and rx
module crc16_byte_next (
    input  logic [15:0] crc,
    input  logic [7:0]  din,
    output logic [15:0] crc_next
);
    logic [7:0] a;
    logic [7:0] ch;
    assign a = din ^ crc[7:0];
    assign ch = a ^ {a[3:0], 4'h0};
    assign crc_next = {ch, crc[15:8]} ^ {5'h0, ch, 3'h0} ^ {12'h0, ch[7:4]};
endmodule

// File: rtl/crc16_frame_tx.sv
// crc16_frame_tx: payload stream transmitter appending CRC-16 and enforcing an inter-frame gap
module crc16_frame_tx
    import crc16_frame_tx_pkg::*;
#(
    parameter int IFG_CYCLES    = 4,
    parameter bit CRC_LSB_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        crc_typ,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [7:0]  s_data,
    input  logic        s_last,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [7:0]  m_data,
    output logic        m_last,
    output logic        busy,
    output logic [15:0] frame_cnt
);
    state_t      state;
    logic [15:0] crc;
    logic [15:0] crc_in;
    logic [15:0] crc_nx;
    logic [15:0] crc_out;
    logic [15:0] gap;
    logic        typ;
    logic        slot_free;
    logic        accept;

    assign slot_free = !m_valid || m_ready;
    assign s_ready   = !rst && (state == IDLE || state == DATA) && slot_free;
    assign accept    = s_valid && s_ready;
    assign busy      = state != IDLE;
    // every frame restarts from the init value, whatever the register holds
    assign crc_in    = state == IDLE ? CRC16_INIT : crc;
    assign crc_out   = typ ? crc : ~crc;

    crc16_byte_next u_next (.crc(crc_in), .din(s_data), .crc_next(crc_nx));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            m_valid   <= 1'b0;
            m_data    <= 8'h00;
            m_last    <= 1'b0;
            crc       <= CRC16_INIT;
            frame_cnt <= 16'h0000;
            gap       <= 16'h0000;
            typ       <= 1'b0;
        end else begin
            if (m_valid && m_ready)
                m_valid <= 1'b0;
            case (state)
                IDLE, DATA: if (accept) begin
                    if (state == IDLE)
                        typ <= crc_typ;
                    crc     <= crc_nx;
                    m_valid <= 1'b1;
                    m_data  <= s_data;
                    m_last  <= 1'b0;
                    state   <= s_last ? CRC_LO : DATA;
                end
                CRC_LO: if (slot_free) begin
                    m_valid <= 1'b1;
                    m_data  <= CRC_LSB_FIRST ? crc_out[7:0] : crc_out[15:8];
                    m_last  <= 1'b0;
                    state   <= CRC_HI;
                end
                CRC_HI: if (slot_free) begin
                    m_valid <= 1'b1;
                    m_data  <= CRC_LSB_FIRST ? crc_out[15:8] : crc_out[7:0];
                    m_last  <= 1'b1;
                    state   <= WAIT_LAST;
                end
                WAIT_LAST: if (m_valid && m_ready) begin
                    frame_cnt <= frame_cnt + 16'd1;
                    gap       <= 16'(IFG_CYCLES);
                    state     <= IFG_CYCLES == 0 ? IDLE : GAP;
                end
                GAP: begin
                    gap   <= gap - 16'd1;
                    state <= gap == 16'd1 ? IDLE : GAP;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_crc16_frame_tx.sv
// tb_crc16_frame_tx: directed self-checking bench for the CRC-16 frame transmitter
module tb_crc16_frame_tx;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        crc_typ = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [7:0]  s_data = 8'h00;
    logic        s_last = 1'b0;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [7:0]  m_data;
    logic        m_last;
    logic        busy;
    logic [15:0] frame_cnt;

    int total = 0;
    int bad = 0;
    bit rnd = 1'b0;
    bit prev_stall = 1'b0;
    logic [8:0] hold_v;
    logic [8:0] out_q[$];
    logic [7:0] pay[$];

    crc16_frame_tx dut (
        .clk(clk), .rst(rst), .crc_typ(crc_typ), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_last(m_last), .busy(busy), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // bitwise reference, independent of the byte-wise table-free form in the RTL
    function automatic logic [15:0] crc_bits(input logic [15:0] c, input logic [7:0] d);
        c = c ^ {8'h00, d};
        for (int k = 0; k < 8; k++)
            c = c[0] ? (c >> 1) ^ 16'h8408 : c >> 1;
        return c;
    endfunction

    always begin
        @(posedge clk);
        #1;
        m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin
        if (!rst && prev_stall)
            check("hold", {m_last, m_data}, hold_v);
        prev_stall = m_valid && !m_ready && !rst;
        hold_v = {m_last, m_data};
        if (m_valid && m_ready && !rst)
            out_q.push_back({m_last, m_data});
    end

    task automatic push(input logic [7:0] d, input bit last, input bit typ);
        int n = 0;
        s_valid = 1'b1;
        s_data = d;
        s_last = last;
        crc_typ = typ;
        do begin
            @(negedge clk);
            n++;
        end while (!s_ready && n < 2000);
        check("accept timeout", n >= 2000, 0);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last = 1'b0;
    endtask

    task automatic frame(input string tag, input bit typ, input logic [7:0] lo,
                         input logic [7:0] hi, input int gapmax);
        int n = 0;
        int tot;
        logic [8:0] e;
        out_q.delete();
        tot = pay.size() + 2;
        @(posedge clk);
        #1;
        foreach (pay[i]) begin
            if (gapmax > 0)
                repeat ($urandom_range(0, gapmax)) begin
                    @(posedge clk);
                    #1;
                end
            push(pay[i], i == pay.size() - 1, typ);
        end
        while (out_q.size() < tot && n < 2000) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({tag, " out timeout"}, n >= 2000, 0);
        for (int i = 0; i < tot; i++) begin
            e = i < pay.size() ? {1'b0, pay[i]} : (i == tot - 1 ? {1'b1, hi} : {1'b0, lo});
            if (i < out_q.size())
                check($sformatf("%s byte%0d", tag, i), out_q[i], e);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, " idle timeout"}, n >= 200, 0);
        @(negedge clk);
    endtask

    initial begin
        logic [15:0] c;
        int n;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst m_valid", m_valid, 0);
        check("rst m_data", m_data, 0);
        check("rst m_last", m_last, 0);
        check("rst s_ready", s_ready, 0);
        check("rst busy", busy, 0);
        check("rst frame_cnt", frame_cnt, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        pay = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        frame("t1", 1'b0, 8'h6E, 8'h90, 0);
        wait_idle("t1");
        check("t1 frame_cnt", frame_cnt, 1);

        frame("t2", 1'b1, 8'h91, 8'h6F, 0);
        wait_idle("t2");
        c = 16'hFFFF;
        foreach (out_q[i]) c = crc_bits(c, out_q[i][7:0]);
        check("t2 residue", c, 16'h0000);
        check("t2 frame_cnt", frame_cnt, 2);

        pay = '{8'h00};
        frame("t3", 1'b1, 8'h87, 8'h0F, 0);
        wait_idle("t3");
        if (out_q.size() == 3)
            check("t3 model", {out_q[2][7:0], out_q[1][7:0]}, crc_bits(16'hFFFF, 8'h00));
        check("t3 frame_cnt", frame_cnt, 3);

        pay = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        rnd = 1'b1;
        frame("t4", 1'b0, 8'h6E, 8'h90, 3);
        rnd = 1'b0;
        wait_idle("t4");
        check("t4 frame_cnt", frame_cnt, 4);

        frame("t5a", 1'b0, 8'h6E, 8'h90, 0);
        @(posedge clk);
        n = 0;
        while (n < 50) begin
            @(negedge clk);
            if (s_ready) break;
            n++;
        end
        check("t5 gap cycles", n, 4);
        frame("t5b", 1'b0, 8'h6E, 8'h90, 0);
        wait_idle("t5");
        check("t5 frame_cnt", frame_cnt, 6);

        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) push(pay[i], 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("t6 m_valid", m_valid, 0);
        check("t6 busy", busy, 0);
        check("t6 frame_cnt", frame_cnt, 0);
        frame("t6", 1'b0, 8'h6E, 8'h90, 0);
        wait_idle("t6");
        check("t6 frame_cnt after", frame_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
